// File: rtl/pc_fetch_unit_if.sv
// Bundles the signals of the fetch unit: the EX redirect, the hazard stall, the
// instruction-memory port and the IF/ID outputs. "master" is the fetch-unit side.
interface pc_fetch_unit_if;
    logic        branch_jump_mux_signal;
    logic [31:0] Branch_jump_PC_OUT;
    logic        hazard_stall;
    logic        imem_busywait;
    logic [31:0] imem_readdata;
    logic        imem_read;
    logic [31:0] imem_address;
    logic [31:0] PC_out;
    logic [31:0] PC_plus4;
    logic [31:0] instruction_out;
    logic        if_id_valid;
    logic        flush;
    logic        misaligned_trap;

    modport master (
        input  branch_jump_mux_signal, Branch_jump_PC_OUT, hazard_stall,
               imem_busywait, imem_readdata,
        output imem_read, imem_address, PC_out, PC_plus4, instruction_out,
               if_id_valid, flush, misaligned_trap
    );

    modport slave (
        output branch_jump_mux_signal, Branch_jump_PC_OUT, hazard_stall,
               imem_busywait, imem_readdata,
        input  imem_read, imem_address, PC_out, PC_plus4, instruction_out,
               if_id_valid, flush, misaligned_trap
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// Fetch-stage PC and instruction-fetch controller with EX redirect and flush.
// Optional macro REDIRECT_ALIGN_CHECK_EN: force target bits[1:0] to 0 and pulse misaligned_trap.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic            CLK,
    input logic            RESET,
    pc_fetch_unit_if.master bus
);
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t      state, state_nx;
    logic [31:0] pc, pc_nx;
    logic [31:0] pending_pc, pending_nx;
    logic [31:0] pc_out, pc_out_nx;
    logic [31:0] instr, instr_nx;
    logic        valid, valid_nx;
    logic        flush, flush_nx;
    logic        trap, trap_nx;
    logic [31:0] target;
    logic        target_mis;

`ifdef REDIRECT_ALIGN_CHECK_EN
    assign target     = {bus.Branch_jump_PC_OUT[31:2], 2'b00};
    assign target_mis = |bus.Branch_jump_PC_OUT[1:0];
`else
    assign target     = bus.Branch_jump_PC_OUT;
    assign target_mis = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            pending_pc <= RESET_PC;
            pc_out     <= 32'd0;
            instr      <= 32'd0;
            valid      <= 1'b0;
            flush      <= 1'b0;
            trap       <= 1'b0;
        end else begin
            state      <= state_nx;
            pc         <= pc_nx;
            pending_pc <= pending_nx;
            pc_out     <= pc_out_nx;
            instr      <= instr_nx;
            valid      <= valid_nx;
            flush      <= flush_nx;
            trap       <= trap_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        pc_nx      = pc;
        pending_nx = pending_pc;
        pc_out_nx  = pc_out;
        instr_nx   = instr;
        valid_nx   = valid;
        flush_nx   = 1'b0;
        trap_nx    = 1'b0;
        case (state)
            IDLE: state_nx = FETCH;
            FETCH: begin
                if (bus.branch_jump_mux_signal) begin
                    flush_nx = 1'b1;
                    trap_nx  = target_mis;
                    valid_nx = 1'b0;
                    // A busy memory must finish its access before the target is issued.
                    if (bus.imem_busywait) begin
                        pending_nx = target;
                        state_nx   = DRAIN;
                    end else begin
                        pc_nx = target;
                    end
                end else if (!bus.hazard_stall) begin
                    if (bus.imem_busywait) begin
                        valid_nx = 1'b0;
                    end else begin
                        instr_nx  = bus.imem_readdata;
                        pc_out_nx = pc;
                        valid_nx  = 1'b1;
                        pc_nx     = pc + 32'd4;
                    end
                end
            end
            DRAIN: begin
                valid_nx = 1'b0;
                if (bus.branch_jump_mux_signal) begin
                    pending_nx = target;
                    flush_nx   = 1'b1;
                    trap_nx    = target_mis;
                end
                // The abandoned word is dropped; the newest target wins.
                if (!bus.imem_busywait) begin
                    pc_nx    = bus.branch_jump_mux_signal ? target : pending_pc;
                    state_nx = FETCH;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign bus.imem_read       = (state != IDLE);
    assign bus.imem_address    = pc;
    assign bus.PC_out          = pc_out;
    assign bus.PC_plus4        = pc_out + 32'd4;
    assign bus.instruction_out = instr;
    assign bus.if_id_valid     = valid;
    assign bus.flush           = flush;
    assign bus.misaligned_trap = trap;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: directed scenarios then random traffic,
// checked against a cycle-level behavioural model of the fetch rules.
module tb_pc_fetch_unit;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic CLK;
    logic RESET;
    pc_fetch_unit_if bus ();

    pc_fetch_unit #(.RESET_PC(RST_PC)) dut (.CLK(CLK), .RESET(RESET), .bus(bus));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    assign bus.imem_readdata = bus.imem_busywait ? 32'hDEAD_BEEF : mem_word(bus.imem_address);

    typedef struct {
        logic        rd;
        logic [31:0] addr;
        logic [31:0] pco;
        logic [31:0] ins;
        logic        vld;
        logic        fl;
        logic        tr;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int failures = 0;

    // Behavioural model: where fetching is, whether an access is being abandoned,
    // and what IF/ID holds.
    int          m_mode;   // 0 = waiting one cycle after reset, 1 = fetching, 2 = abandoning
    logic [31:0] m_next, m_later, m_pco, m_ins;
    logic        m_vld, m_fl, m_tr;

    task automatic model_step(input logic r, rd, input logic [31:0] t, input logic st, bz);
        logic [31:0] eff;
        logic        mis;
        exp_t        e;
`ifdef REDIRECT_ALIGN_CHECK_EN
        eff = t & 32'hFFFF_FFFC;
        mis = (t[1:0] != 2'b00);
`else
        eff = t;
        mis = 1'b0;
`endif
        if (!r) begin
            m_mode = 0; m_next = RST_PC; m_later = RST_PC;
            m_pco = 0; m_ins = 0; m_vld = 0; m_fl = 0; m_tr = 0;
        end else begin
            m_fl = 0; m_tr = 0;
            if (m_mode == 0) begin
                m_mode = 1;
            end else if (m_mode == 1) begin
                if (rd) begin
                    m_fl = 1; m_tr = mis; m_vld = 0;
                    if (bz) begin m_later = eff; m_mode = 2; end
                    else m_next = eff;
                end else if (!st) begin
                    if (bz) m_vld = 0;
                    else begin
                        m_ins = mem_word(m_next); m_pco = m_next; m_vld = 1;
                        m_next = m_next + 4;
                    end
                end
            end else begin
                m_vld = 0;
                if (rd) begin m_later = eff; m_fl = 1; m_tr = mis; end
                if (!bz) begin m_next = m_later; m_mode = 1; end
            end
        end
        e.rd = (m_mode != 0); e.addr = m_next; e.pco = m_pco; e.ins = m_ins;
        e.vld = m_vld; e.fl = m_fl; e.tr = m_tr;
        q.push_back(e);
    endtask

    task automatic drive(input logic r, rd, input logic [31:0] t, input logic st, bz);
        @(negedge CLK);
        RESET = r;
        bus.branch_jump_mux_signal = rd;
        bus.Branch_jump_PC_OUT = t;
        bus.hazard_stall = st;
        bus.imem_busywait = bz;
        model_step(r, rd, t, st, bz);
        @(posedge CLK);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    always @(posedge CLK) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("imem_read", {31'd0, bus.imem_read}, {31'd0, e.rd});
            chk("imem_address", bus.imem_address, e.addr);
            chk("PC_out", bus.PC_out, e.pco);
            chk("PC_plus4", bus.PC_plus4, e.pco + 32'd4);
            chk("instruction_out", bus.instruction_out, e.ins);
            chk("if_id_valid", {31'd0, bus.if_id_valid}, {31'd0, e.vld});
            chk("flush", {31'd0, bus.flush}, {31'd0, e.fl});
            chk("misaligned_trap", {31'd0, bus.misaligned_trap}, {31'd0, e.tr});
        end
    end

    initial begin
        logic [31:0] t;
        RESET = 1'b0;
        bus.branch_jump_mux_signal = 1'b0;
        bus.Branch_jump_PC_OUT = 32'd0;
        bus.hazard_stall = 1'b0;
        bus.imem_busywait = 1'b0;
        // Reset, idle cycle, sequential fetch 0,4
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        // Busy three cycles at 8, then 8 and C delivered
        repeat (3) drive(1, 0, 0, 0, 1);
        drive(1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        // Redirect to 0x100 while fetching 0x10
        drive(1, 1, 32'h100, 0, 0);
        drive(1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        // Redirect to 0x14, busy there, then redirect to 0x200 during busywait
        drive(1, 1, 32'h14, 0, 0);
        drive(1, 0, 0, 0, 1);
        drive(1, 1, 32'h200, 0, 1);
        drive(1, 0, 0, 1, 1);
        drive(1, 0, 0, 0, 1);
        drive(1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        // Stall colliding with redirect to 0x40, then stall alone
        drive(1, 1, 32'h40, 1, 0);
        drive(1, 0, 0, 0, 0);
        repeat (3) drive(1, 0, 0, 1, 0);
        drive(1, 0, 0, 1, 1);
        drive(1, 0, 0, 0, 0);
        // Misaligned redirect, then wrap-around past 0xFFFF_FFFC
        drive(1, 1, 32'h102, 0, 0);
        drive(1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        drive(1, 1, 32'hFFFF_FFF8, 0, 0);
        repeat (3) drive(1, 0, 0, 0, 0);
        // Reset in the middle of a drain
        drive(1, 1, 32'h300, 0, 1);
        drive(0, 0, 0, 0, 1);
        drive(1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            t = $urandom & 32'h0000_0FFC;
            if ($urandom_range(0, 9) == 0) t = t | 32'hFFFF_F000;
            if ($urandom_range(0, 3) == 0) t = t | 32'($urandom_range(1, 3));
            drive(($urandom_range(0, 199) != 0), ($urandom_range(0, 7) == 0), t,
                  ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0));
        end
        drive(1, 0, 0, 0, 0);
        @(negedge CLK);
        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Fetch-stage program counter and instruction-fetch controller for the 5-stage RV32I pipeline. Consumes the redirect request and target produced by the EX-stage branch/jump unit, sequences instruction-memory reads under `busywait`, and feeds the IF/ID register. It also produces the pipeline flush for the wrong-path instructions. It is the receiving end of the branch/jump redirect interface.

## Interface
- `RESET_PC`, default 32'h0000_0000, PC loaded on reset.

- `CLK` in 1, the single clock; all state updates on the rising edge.
- `RESET` in 1, synchronous, active-low reset.
- `branch_jump_mux_signal` in 1, redirect request from EX; valid for the cycle it is high.
- `Branch_jump_PC_OUT` in 32, redirect target; sampled only when the redirect is high.
- `hazard_stall` in 1, load-use stall from the hazard unit.
- `imem_busywait` in 1, instruction memory not ready.
- `imem_readdata` in 32, instruction word; valid when `imem_read`=1 and `imem_busywait`=0.
- `imem_read` out 1, instruction-memory read strobe.
- `imem_address` out 32, fetch address.
- `PC_out` out 32, PC of the instruction in IF/ID.
- `PC_plus4` out 32, `PC_out`+4.
- `instruction_out` out 32, instruction word to IF/ID.
- `if_id_valid` out 1, IF/ID holds a live instruction.
- `flush` out 1, one-cycle kill of IF/ID and ID/EX.
- `misaligned_trap` out 1, redirect-target misalignment pulse.

## Operation
- States:
  - IDLE: one cycle after reset.
  - FETCH: normal fetching.
  - DRAIN: an abandoned memory access is completing.
- Internal registers:
  - `pc`: next fetch address.
  - `pending_pc`: redirect target held during DRAIN.
- Reset (RESET=0 at an edge):
  - `pc`=RESET_PC and state=IDLE.
  - `PC_out`, `instruction_out`, `if_id_valid`, `flush` and `misaligned_trap` are all 0.
  - `PC_plus4` is 4.
- IDLE: `imem_read`=0 for one cycle, then the unit moves to FETCH.
- In FETCH, `imem_read`=1 and `imem_address`=`pc`. Priority at each edge is highest first:
  1. **Redirect**:
     - `flush` is set to 1 for the next cycle and `if_id_valid` is set to 0.
     - If `imem_busywait`=0: `pc` takes the target.
     - If `imem_busywait`=1: `pending_pc` takes the target and the state moves to DRAIN.
     - Redirect overrides `hazard_stall`.
  2. **hazard_stall=1**: `pc`, `PC_out`, `instruction_out` and `if_id_valid` all hold. This applies even if memory completes in this cycle; the same address is re-read later.
  3. **imem_busywait=1**: `pc` holds and `if_id_valid` is set to 0 (bubble).
  4. **Otherwise**:
     - `instruction_out` takes `imem_readdata` and `PC_out` takes `pc`.
     - `if_id_valid` is set to 1.
     - `pc` advances to `pc`+4.
- In DRAIN, `imem_read`=1 and `imem_address` keeps the abandoned address, so the memory request is never changed mid-access.
  - When `imem_busywait`=0, the returned data is discarded, `pc` takes `pending_pc` and the state returns to FETCH.
  - A further redirect during DRAIN overwrites `pending_pc` and asserts `flush` again.
  - `hazard_stall` is ignored in DRAIN.
  - `if_id_valid` stays 0.
- Arithmetic: 32-bit modulo 2^32, so 32'hFFFF_FFFC+4 = 0. `PC_plus4` is combinational from `PC_out`.

## Timing
- `imem_address` and `imem_read` are combinational from state and `pc`.
- All other outputs are registered.
- Fetch-to-IF/ID latency with zero-wait memory: one cycle; throughput is one instruction per cycle.
- Redirect latency:
  - Redirect is high at edge N.
  - `flush`=1 during cycle N+1, and `imem_address`=target during cycle N+1 when not draining.
  - The target's instruction appears in IF/ID after edge N+1.
- `flush` is never high two consecutive cycles unless two redirects arrive on consecutive edges.
- Reset has priority over everything, including reset mid-DRAIN. The pending target is lost.

## Configuration
- `REDIRECT_ALIGN_CHECK_EN`:
  - **Defined**: a redirect target with bits[1:0]≠0 pulses `misaligned_trap`=1 for one cycle, alongside `flush`. The target is used with bits[1:0] forced to 00.
  - **Undefined**: the target is used verbatim, and `misaligned_trap` is tied 0.

## Test plan
- **Reset and sequential fetch**: RESET_PC=0 with zero-wait memory, release reset. Required: one IDLE cycle, then `imem_address` sequence 0,4,8,C, with `PC_out` lagging one cycle and `if_id_valid`=1.
- **Busywait**: `imem_busywait` high for 3 cycles at address 8. Required: `pc` holds at 8, 3 bubbles with `if_id_valid`=0, then instruction 8 is delivered with `PC_out`=8.
- **Redirect with idle memory**: redirect to 32'h100 while fetching 0x10. Required: `flush`=1 for one cycle, the next `imem_address` is 0x100, and instruction 0x10 never appears as valid.
- **Redirect during busywait**: redirect to 0x200 while busywait is high at 0x14, busy for 2 more cycles. Required: address stays 0x14 until busy drops, its data is discarded, then the fetch is from 0x200.
- **Stall/redirect collision**: `hazard_stall` and redirect to 0x40 on the same edge. Required: the redirect wins, `flush`=1 and `pc`=0x40. With stall alone, IF/ID holds its values unchanged for the stalled cycles.
- **Alignment check**, with `REDIRECT_ALIGN_CHECK_EN` defined: redirect to 0x102. Required: `misaligned_trap`=1 for one cycle and the fetch is from 0x100. With the macro undefined, the fetch is from 0x102 and the trap stays 0.
